// File: rtl/mult_seq.sv
// Multiply sequencer: drives a registered 32x32 unsigned multiplier and sign-corrects the result.
// Optional result reuse cache enabled by MULT_SEQ_REUSE_EN.
module mult_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  op,
  input  logic        start,
  output logic [31:0] y,
  output logic        done,
  output logic        busy,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_start,
  input  logic [63:0] mul_y,
  input  logic        mul_done
);

`ifdef MULT_SEQ_REUSE_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIX, HIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIX} state_t;
`endif

  state_t      state_q, state_d;
  logic        hi_q, hi_d;
  logic        neg_q, neg_d;
  logic [31:0] mul_a_q, mul_a_d;
  logic [31:0] mul_b_q, mul_b_d;
  logic        mul_start_q, mul_start_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] y_q, y_d;
  logic        done_q, done_d;

  logic        sgn;
  logic [63:0] p;

  assign sgn = ~op[0];
  assign p   = neg_q ? (~prod_q + 64'd1) : prod_q;

`ifdef MULT_SEQ_REUSE_EN
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sgn_q, sgn_d;
  logic        cv_q, cv_d;
  logic [31:0] ca_q, ca_d;
  logic [31:0] cb_q, cb_d;
  logic        cs_q, cs_d;
  logic [63:0] cp_q, cp_d;
  logic        hit;

  // Cached p is already sign-corrected, so only the word select varies.
  assign hit = cv_q & (a == ca_q) & (b == cb_q) & (sgn == cs_q);
`endif

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    neg_d       = neg_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_start_d = 1'b0;
    prod_d      = prod_q;
    y_d         = y_q;
    done_d      = 1'b0;
`ifdef MULT_SEQ_REUSE_EN
    a_d   = a_q;
    b_d   = b_q;
    sgn_d = sgn_q;
    cv_d  = cv_q;
    ca_d  = ca_q;
    cb_d  = cb_q;
    cs_d  = cs_q;
    cp_d  = cp_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          hi_d    = op[1];
          neg_d   = sgn & (a[31] ^ b[31]);
          mul_a_d = (sgn & a[31]) ? -a : a;
          mul_b_d = (sgn & b[31]) ? -b : b;
`ifdef MULT_SEQ_REUSE_EN
          a_d   = a;
          b_d   = b;
          sgn_d = sgn;
          if (hit) begin
            state_d = HIT;
          end else begin
            state_d     = ISSUE;
            mul_start_d = 1'b1;
          end
`else
          state_d     = ISSUE;
          mul_start_d = 1'b1;
`endif
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mul_done) begin
          prod_d  = mul_y;
          state_d = FIX;
        end
      end
      FIX: begin
        y_d     = hi_q ? p[63:32] : p[31:0];
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef MULT_SEQ_REUSE_EN
        cv_d = 1'b1;
        ca_d = a_q;
        cb_d = b_q;
        cs_d = sgn_q;
        cp_d = p;
`endif
      end
`ifdef MULT_SEQ_REUSE_EN
      HIT: begin
        y_d     = hi_q ? cp_q[63:32] : cp_q[31:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hi_q        <= 1'b0;
      neg_q       <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      prod_q      <= '0;
      y_q         <= '0;
      done_q      <= 1'b0;
`ifdef MULT_SEQ_REUSE_EN
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      cv_q  <= 1'b0;
      ca_q  <= '0;
      cb_q  <= '0;
      cs_q  <= 1'b0;
      cp_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      neg_q       <= neg_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      prod_q      <= prod_d;
      y_q         <= y_d;
      done_q      <= done_d;
`ifdef MULT_SEQ_REUSE_EN
      a_q   <= a_d;
      b_q   <= b_d;
      sgn_q <= sgn_d;
      cv_q  <= cv_d;
      ca_q  <= ca_d;
      cb_q  <= cb_d;
      cs_q  <= cs_d;
      cp_q  <= cp_d;
`endif
    end
  end

  assign y         = y_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_start = mul_start_q;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq with a 2-cycle multiplier model and a result scoreboard.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [1:0]  op;
  logic        start;
  logic [31:0] y;
  logic        done, busy;
  logic [31:0] mul_a, mul_b;
  logic        mul_start;
  logic [63:0] mul_y = '0;
  logic        mul_done;
  logic [1:0]  pipe = '0;
  logic        stale = 1'b0;

`ifdef MULT_SEQ_REUSE_EN
  localparam int HL = 2;
`else
  localparam int HL = 5;
`endif

  mult_seq dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
    .y(y), .done(done), .busy(busy), .mul_a(mul_a), .mul_b(mul_b),
    .mul_start(mul_start), .mul_y(mul_y), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe  <= {pipe[0], mul_start};
    mul_y <= {32'b0, mul_a} * {32'b0, mul_b};
  end
  assign mul_done = pipe[1] | stale;

  int total = 0;
  int bad = 0;
  int ms_cnt = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pop;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) if (mul_start) ms_cnt++;

  always @(negedge clk) begin
    if (done && !reset) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=%0h required=none", y);
      end else begin
        exp_pop = sb.pop_front();
        chk("y", {32'b0, y}, {32'b0, exp_pop});
      end
    end
  end

  function automatic logic [31:0] ref_y(input logic [1:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] z);
    logic signed [63:0] sx, sz, pr;
    if (!o[0]) begin
      sx = $signed({{32{x[31]}}, x});
      sz = $signed({{32{z[31]}}, z});
      pr = sx * sz;
    end else begin
      pr = {32'b0, x} * {32'b0, z};
    end
    return o[1] ? pr[63:32] : pr[31:0];
  endfunction

  task automatic do_op(input bit chain, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] z,
                       input logic [31:0] e, input int lat,
                       input int extra, input bit chkm,
                       input logic [31:0] ema, input logic [31:0] emb);
    int n;
    int ms0;
    bit busy_ok;
    if (!chain) @(negedge clk);
    op = o; a = x; b = z; start = 1'b1;
    sb.push_back(e);
    ms0 = ms_cnt;
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      start = (n == extra);
      if (n == extra) begin
        op = ~o; a = x ^ 32'h5; b = z + 32'd9;
      end
      if (n < lat && !busy) busy_ok = 1'b0;
      if (chkm && n == 3) begin
        chk("mul_a_hold", {32'b0, mul_a}, {32'b0, ema});
        chk("mul_b_hold", {32'b0, mul_b}, {32'b0, emb});
      end
    end while (!done && n < 20);
    start = 1'b0;
    chk("latency", 64'(n), 64'(lat));
    chk("busy", {63'b0, busy_ok}, 64'd1);
    chk("mul_start_cnt", 64'(ms_cnt - ms0), (lat == 5) ? 64'd1 : 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, y;
    int          lat;
    bit          chkm;
    logic [31:0] ma, mb;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int dcnt;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    tbl[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 5, 0, 0, 0};
    tbl[1] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, HL, 0, 0, 0};
    tbl[2] = '{2'b00, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 5, 1, 32'h3, 32'h7};
    tbl[3] = '{2'b10, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, HL, 0, 0, 0};
    tbl[4] = '{2'b10, 32'h80000000, 32'h80000000, 32'h40000000, 5, 1,
               32'h80000000, 32'h80000000};
    tbl[5] = '{2'b00, 32'h80000000, 32'h80000000, 32'h00000000, HL, 0, 0, 0};
    tbl[6] = '{2'b00, 32'h0, 32'hFFFFFFFF, 32'h00000000, 5, 0, 0, 0};

    reset = 1'b1; a = '0; b = '0; op = '0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_y", {32'b0, y}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_mul_start", {63'b0, mul_start}, 64'd0);
    chk("rst_mul_a", {32'b0, mul_a}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      do_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].lat,
            0, tbl[i].chkm, tbl[i].ma, tbl[i].mb);

    // extra start mid-flight, then a start on the done cycle
    do_op(1'b0, 2'b01, 32'h1234, 32'h10, 32'h12340, 5, 2, 1'b1,
          32'h1234, 32'h10);
    do_op(1'b1, 2'b00, 32'hFFFFFF00, 32'h3, 32'hFFFFFD00, 5, 0, 1'b0, 0, 0);

    // reset during WAIT abandons the op
    @(negedge clk);
    op = 2'b01; a = 32'd100; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_y", {32'b0, y}, 64'd0);
    chk("mid_rst_done", {63'b0, done}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_mul_start", {63'b0, mul_start}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stale = 1'b1;
    @(negedge clk);
    stale = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("no_done_after_rst", 64'(dcnt), 64'd0);
    do_op(1'b0, 2'b01, 32'd6, 32'd7, 32'd42, 5, 0, 1'b0, 0, 0);

    // reuse sequence: prime, hit low, hit high, sgn change misses
    do_op(1'b0, 2'b00, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 5, 0, 1'b0, 0, 0);
    do_op(1'b0, 2'b00, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, HL, 0, 1'b0, 0, 0);
    do_op(1'b0, 2'b10, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, HL, 0, 1'b0, 0, 0);
    do_op(1'b0, 2'b01, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 5, 0, 1'b0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      do_op(1'b0, ro, ra, rb, ref_y(ro, ra, rb), 5, 0, 1'b0, 0, 0);
    end

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
